morse_player: RTL

- Sequencer that plays one Morse character, as produced by codifMorse, out over time on a single lamp, with ITU timing: dot 1 unit, dash 3 units, intra-character gap 1 unit, character gap 3 units.
- Sits between codifMorse (symbol pattern source) and sevSeg/LED output.
- Latches a pattern on a start strobe, times each symbol with an internal unit prescaler, and reports busy/done to the upper-level controller.

---
 rtl/morse_pkg.sv | 33 +++
 rtl/morse_unit_timer.sv | 27 ++
 rtl/morse_player.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse character player.
// pattern_len() gives the number of leading valid symbols in a display mask.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    CGAP,
    FIN
  } state_t;

  localparam int MORSE_LEN      = 5;
  localparam int DEF_DASH_UNITS = 3;
  localparam int DEF_CGAP_UNITS = 3;

  // Counts consecutive 1s from the MSB down; the first 0 ends the character.
  function automatic logic [2:0] pattern_len(input logic [MORSE_LEN-1:0] mask);
    logic [2:0] n;
    logic       run;
    n   = 3'd0;
    run = 1'b1;
    for (int i = MORSE_LEN - 1; i >= 0; i--) begin
      if (run && mask[i]) begin
        n = n + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter; expired is high in any cycle the count reads zero.
// A load takes priority over counting, and the count holds at zero.
module morse_unit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/morse_player.sv
// Plays one latched Morse character on a lamp with ITU unit timing.
// Outputs are registered from the next-state values, so led rises one cycle after start.
module morse_player
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int DASH_UNITS  = DEF_DASH_UNITS,
  parameter int CGAP_UNITS  = DEF_CGAP_UNITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 cancel,
  input  logic [MORSE_LEN-1:0] morse,
  input  logic [MORSE_LEN-1:0] display,
  output logic                 led,
  output logic                 ponto,
  output logic                 traco,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           sym_idx
);

  localparam int MAX_UNITS = (DASH_UNITS > CGAP_UNITS) ? DASH_UNITS : CGAP_UNITS;
  localparam int TW_RAW    = $clog2(MAX_UNITS * UNIT_CYCLES);
  localparam int TW        = (TW_RAW < 1) ? 1 : TW_RAW;

  // Loads are duration-1 because expiry is the cycle the counter reads zero.
  localparam logic [TW-1:0] DOT_LOAD  = TW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] DASH_LOAD = TW'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [TW-1:0] CGAP_LOAD = TW'(CGAP_UNITS * UNIT_CYCLES - 1);

  state_t                 state_reg, state_next;
  logic [MORSE_LEN-1:0]   morse_reg, morse_next;
  logic [MORSE_LEN-1:0]   display_reg, display_next;
  logic [2:0]             sym_idx_reg, sym_idx_next;
  logic                   led_reg, ponto_reg, traco_reg, busy_reg, done_reg;

  logic                   mark_bit_next;
  logic                   timer_load;
  logic [TW-1:0]          timer_val;
  logic                   timer_expired;

  logic [MORSE_LEN-1:0]   sym_bits;
  logic [2:0]             sym_idx_inc;
  logic                   cur_bit;
  logic                   next_bit;
  logic                   has_next;

  // Reverse the latched pattern so sym_idx indexes play order directly.
  for (genvar gi = 0; gi < MORSE_LEN; gi++) begin : g_sym_order
    assign sym_bits[gi] = morse_reg[MORSE_LEN-1-gi];
  end

  assign sym_idx_inc = sym_idx_reg + 3'd1;
  assign cur_bit     = sym_bits[sym_idx_reg];
  assign next_bit    = sym_bits[sym_idx_inc];
  assign has_next    = (sym_idx_inc < pattern_len(display_reg));

  morse_unit_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  always_comb begin
    state_next    = state_reg;
    morse_next    = morse_reg;
    display_next  = display_reg;
    sym_idx_next  = sym_idx_reg;
    mark_bit_next = cur_bit;
    timer_load    = 1'b0;
    timer_val     = DOT_LOAD;

    case (state_reg)
      IDLE: begin
        if (start) begin
          morse_next    = morse;
          display_next  = display;
          sym_idx_next  = 3'd0;
          mark_bit_next = morse[MORSE_LEN-1];
          timer_load    = 1'b1;
          timer_val     = morse[MORSE_LEN-1] ? DOT_LOAD : DASH_LOAD;
          state_next    = display[MORSE_LEN-1] ? MARK : FIN;
        end
      end
      MARK: begin
        if (timer_expired) begin
          timer_load = 1'b1;
          if (has_next) begin
            timer_val  = DOT_LOAD;
            state_next = SPACE;
          end else begin
            timer_val  = CGAP_LOAD;
            state_next = CGAP;
          end
        end
      end
      SPACE: begin
        if (timer_expired) begin
          sym_idx_next  = sym_idx_inc;
          mark_bit_next = next_bit;
          timer_load    = 1'b1;
          timer_val     = next_bit ? DOT_LOAD : DASH_LOAD;
          state_next    = MARK;
        end
      end
      CGAP: begin
        if (timer_expired) begin
          state_next = FIN;
        end
      end
      FIN: begin
        sym_idx_next = 3'd0;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous start in IDLE.
    if (cancel) begin
      state_next   = IDLE;
      morse_next   = morse_reg;
      display_next = display_reg;
      sym_idx_next = 3'd0;
      timer_load   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      morse_reg   <= '0;
      display_reg <= '0;
      sym_idx_reg <= 3'd0;
      led_reg     <= 1'b0;
      ponto_reg   <= 1'b0;
      traco_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      morse_reg   <= morse_next;
      display_reg <= display_next;
      sym_idx_reg <= sym_idx_next;
      led_reg     <= (state_next == MARK);
      ponto_reg   <= (state_next == MARK) && mark_bit_next;
      traco_reg   <= (state_next == MARK) && !mark_bit_next;
      busy_reg    <= (state_next == MARK) || (state_next == SPACE) || (state_next == CGAP);
      done_reg    <= (state_next == FIN);
    end
  end

  assign led     = led_reg;
  assign ponto   = ponto_reg;
  assign traco   = traco_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign sym_idx = sym_idx_reg;

endmodule
